// File: rtl/vga_controller.sv
// 640x480@60 VGA timing with an RGB332 framebuffer fetch and a colour-bar pattern; 2 pixel slots (4 clocks) from counters to pins.
// No backpressure: the framebuffer must return fb_data one clock after fb_addr/fb_rd.
module vga_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19
) (
  input  logic              clock_50,
  input  logic              reset_n,
  input  logic              en,
  input  logic              pattern_sel,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [7:0]        fb_data,
  output logic              frame_start,
  output logic              vblank,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK,
  output logic              VGA_SYNC,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B
);

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOT);
  localparam int VW       = $clog2(V_TOT);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int BAR_W    = H_ACTIVE / 8;

  logic              pix_en;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              h_last, v_last, act0, hs0, vs0;
  logic [2:0]        bar0, bar1, bar_rgb;
  logic              act1, hs1, vs1, en1, pat1;
  logic [23:0]       rgb;

  assign h_last   = (h_cnt == HW'(H_TOT - 1));
  assign v_last   = (v_cnt == VW'(V_TOT - 1));
  assign act0     = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign hs0      = !((h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END)));
  assign vs0      = !((v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END)));
  assign VGA_SYNC = 1'b0;

  // Bar index by threshold compares so no divider is needed.
  always_comb begin
    bar0 = 3'd0;
    for (int i = 1; i < 8; i++)
      if (h_cnt >= HW'(i * BAR_W)) bar0 = 3'(i);
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      pix_en      <= 1'b0;
      VGA_CLK     <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      VGA_CLK     <= ~pix_en;
      vblank      <= (v_cnt >= VW'(V_ACTIVE));
      frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      addr_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (h_last && v_last)
        addr_cnt <= '0;
      else if (act0)
        addr_cnt <= addr_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      fb_addr <= '0;
      fb_rd   <= 1'b0;
      act1    <= 1'b0;
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      en1     <= 1'b0;
      pat1    <= 1'b0;
      bar1    <= 3'd0;
    end else if (pix_en) begin
      fb_addr <= addr_cnt;
      fb_rd   <= act0 && en && !pattern_sel;
      act1    <= act0;
      hs1     <= hs0;
      vs1     <= vs0;
      en1     <= en;
      pat1    <= pattern_sel;
      bar1    <= bar0;
    end
  end

  // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to R=~b[1], G=~b[2], B=~b[0].
  assign bar_rgb = ~{bar1[1], bar1[2], bar1[0]};

  always_comb begin
    rgb = '0;
    if (act1 && en1) begin
      if (pat1)
        rgb = {{8{bar_rgb[2]}}, {8{bar_rgb[1]}}, {8{bar_rgb[0]}}};
      else
        rgb = {fb_data[7:5], fb_data[7:5], fb_data[7:6],
               fb_data[4:2], fb_data[4:2], fb_data[4:3],
               {4{fb_data[1:0]}}};
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BLANK <= 1'b0;
      VGA_R     <= 8'd0;
      VGA_G     <= 8'd0;
      VGA_B     <= 8'd0;
    end else if (pix_en) begin
      VGA_HS    <= hs1;
      VGA_VS    <= vs1;
      VGA_BLANK <= act1;
      {VGA_R, VGA_G, VGA_B} <= rgb;
    end
  end

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller on a shrunken raster; per-slot expected pins are queued when a slot is fetched and compared when it reaches the pins.
module tb_vga_controller;

  localparam int HA = 32, HFP = 2, HSY = 4, HBP = 2;
  localparam int VA = 6, VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FS = HT * VT;

  logic        clock_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b1;
  logic        pattern_sel = 1'b0;
  logic [18:0] fb_addr;
  logic        fb_rd;
  logic [7:0]  fb_data;
  logic        frame_start, vblank;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  vga_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .ADDR_W(19)
  ) dut (
    .clock_50(clock_50), .reset_n(reset_n), .en(en), .pattern_sel(pattern_sel),
    .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_data(fb_data),
    .frame_start(frame_start), .vblank(vblank),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
    .VGA_SYNC(VGA_SYNC), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 clock_50 = ~clock_50;

  logic [7:0]  data_tab [8] = '{8'hE0, 8'h1C, 8'h03, 8'h40, 8'hFF, 8'h00, 8'h92, 8'h6D};
  logic [23:0] exp_tab  [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h490000,
                                24'hFFFFFF, 24'h000000, 24'h9292AA, 24'h6D6D55};
  logic [23:0] bar_tab  [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Framebuffer with one clock of read latency.
  always @(posedge clock_50) fb_data <= data_tab[fb_addr[2:0] ^ fb_addr[5:3]];

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [26:0] exp_q[$];
  bit agg_on = 1'b0;
  int hs_low = 0, vs_low = 0, vb_hi = 0, rd_hi = 0, fs_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t, edge %0d)", tag, got, exp, $time, n);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pins"}, 32'({VGA_BLANK, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}), 32'({3'b011, 24'h0}));
    check({tag, "_vga_clk"}, 32'(VGA_CLK), 32'd0);
    check({tag, "_vga_sync"}, 32'(VGA_SYNC), 32'd0);
    check({tag, "_fb_rd"}, 32'(fb_rd), 32'd0);
    check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_vblank"}, 32'(vblank), 32'd0);
  endtask

  // One clock after reset release; slot k is fetched at edge 2+2k and shown at edge 4+2k.
  task automatic step();
    int s, k, x, y;
    logic act, hs, vs, fs_exp;
    logic [18:0] a;
    logic [23:0] rgb;
    logic [26:0] exp_pins;
    @(posedge clock_50);
    n++;
    @(negedge clock_50);
    check("vga_clk", 32'(VGA_CLK), 32'(n % 2));
    fs_exp = (n >= 2) && (n % 2 == 0) && (((n - 2) / 2) % FS == 0);
    check("frame_start", 32'(frame_start), 32'(fs_exp));
    s = ((n - 1) / 2) % FS;
    check("vblank", 32'(vblank), 32'((s / HT) >= VA));
    if (n % 2 == 0) begin
      if (n >= 4) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
        else check("pins", 32'({VGA_BLANK, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}), 32'(exp_q.pop_front()));
      end
      k = ((n - 2) / 2) % FS;
      x = k % HT;
      y = k / HT;
      act = (x < HA) && (y < VA);
      hs = !((x >= HA + HFP) && (x < HA + HFP + HSY));
      vs = !((y >= VA + VFP) && (y < VA + VFP + VSY));
      a = 19'(y * HA + x);
      rgb = 24'h0;
      if (act && en) rgb = pattern_sel ? bar_tab[x / (HA / 8)] : exp_tab[a[2:0] ^ a[5:3]];
      check("fb_rd", 32'(fb_rd), 32'(act && en && !pattern_sel));
      if (act) check("fb_addr", 32'(fb_addr), 32'(a));
      exp_pins = {act, hs, vs, rgb};
      exp_q.push_back(exp_pins);
    end
    if (agg_on) begin
      if (!VGA_HS) hs_low++;
      if (!VGA_VS) vs_low++;
      if (vblank) vb_hi++;
      if (fb_rd) rd_hi++;
      if (frame_start) fs_cnt++;
      if (n == 2 * FS) begin
        check("hs_low_clks", 32'(hs_low), 32'(2 * HSY * VT));
        check("vs_low_clks", 32'(vs_low), 32'(2 * VSY * HT));
        check("vblank_clks", 32'(vb_hi), 32'(2 * (VT - VA) * HT));
        check("fb_rd_clks", 32'(rd_hi), 32'(2 * HA * VA));
        check("frame_starts", 32'(fs_cnt), 32'd1);
        agg_on = 1'b0;
      end
    end
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clock_50);
    @(negedge clock_50);
    check_reset("rst_hold");
    reset_n = 1'b1;
    n = 0;
    agg_on = 1'b1;
    repeat (2 * FS + 20) step();        // full frame plus wrap into the next
    pattern_sel = 1'b1;
    repeat (2 * FS) step();
    pattern_sel = 1'b0;
    en = 1'b0;
    repeat (2 * FS) step();
    en = 1'b1;
    guard = 0;
    while (((n / 2) % FS) != (2 * HT + HA / 2 + 2) && guard < 2 * FS) begin
      step();
      guard++;
    end
    reset_n = 1'b0;
    #1;
    check_reset("async_rst");
    repeat (2) @(posedge clock_50);
    @(negedge clock_50);
    check_reset("rst_mid_hold");
    reset_n = 1'b1;
    n = 0;
    exp_q.delete();
    repeat (4 * HT) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
